// File: rtl/sum_accumulator_16b.sv
// Batch accumulator for 16-bit adder results.
// A batch opens with start/len in IDLE, then takes len results ({cout, sum},
// zero-extended) through an in_valid/in_ready handshake. The total, with a
// sticky wrap flag, is held in DONE until the downstream block takes it.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, len         open a batch of len results (sampled in IDLE only)
//   in_valid, in_ready upstream handshake; in_ready is high only in ACCUM
//   in_sum, in_cout    17-bit operand from the upstream adder
//   acc                running and final total, ACC_W bits
//   acc_valid          final total presented (DONE)
//   acc_ready          downstream takes the total
//   ovf                accumulator wrapped during the current batch (sticky)
//   busy               state is not IDLE
module sum_accumulator_16b #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [15:0]      in_sum,
  input  logic             in_cout,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [SUM_W-1:0] sum_ext;

  // Unmodded sum; its MSB marks a wrap of the ACC_W-bit accumulator.
  assign sum_ext = SUM_W'(acc) + SUM_W'({in_cout, in_sum});

  // Handshake/status flags are plain decodes of the state register.
  assign in_ready  = (state == ACCUM);
  assign acc_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Batch control and accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= len;
            if (len != '0) begin
              state <= ACCUM;
            end else begin
              state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= sum_ext[ACC_W-1:0];
            if (sum_ext[ACC_W]) begin
              ovf <= 1'b1;
            end
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // Start seen on this edge is dropped: one IDLE cycle between batches.
          if (acc_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator_16b.sv
// Self-checking bench for sum_accumulator_16b (ACC_W = 18 so the wrap case is
// reachable). Expected totals go into a scoreboard queue when a batch is
// started and are compared whenever the DUT hands a total downstream.
module tb_sum_accumulator_16b;

  localparam int unsigned ACC_W = 18;
  localparam int unsigned LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [15:0]      in_sum;
  logic             in_cout;
  logic             in_ready;
  logic [ACC_W-1:0] acc;
  logic             acc_valid;
  logic             acc_ready;
  logic             ovf;
  logic             busy;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  sum_accumulator_16b #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_ready  (in_ready),
    .acc       (acc),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to 1 ns after the next rising edge; all driving and direct checks
  // happen in this phase.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [ACC_W-1:0] a, input logic o);
    exp_t e;
    e.acc = a;
    e.ovf = o;
    sb_q.push_back(e);
  endtask

  task automatic start_batch(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = LEN_W'($urandom);
  endtask

  // One transfer on the next edge; operands are scrambled afterwards since
  // they must be ignored without in_valid.
  task automatic send(input logic [15:0] s, input logic c);
    in_valid = 1'b1;
    in_sum   = s;
    in_cout  = c;
    tick();
    in_valid = 1'b0;
    in_sum   = 16'($urandom);
    in_cout  = 1'($urandom);
  endtask

  // Scoreboard: every presented total must have been expected; compare on handoff.
  always @(negedge clk) begin
    if (acc_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_acc_valid", 32'(acc_valid), 32'd0);
      end else if (acc_ready) begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_acc", 32'(acc), 32'(e.acc));
        check_eq("sb_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_cout   = 1'b0;
    acc_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    check_eq("rst_acc",       32'(acc), 32'd0);
    check_eq("rst_ovf",       32'(ovf), 32'd0);
    check_eq("rst_in_ready",  32'(in_ready), 32'd0);
    check_eq("rst_acc_valid", 32'(acc_valid), 32'd0);
    check_eq("rst_busy",      32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Basic batch: 45 + 41 = 86.
    push_exp(18'd86, 1'b0);
    start_batch(8'd2);
    check_eq("basic_in_ready", 32'(in_ready), 32'd1);
    check_eq("basic_busy",     32'(busy), 32'd1);
    send(16'h002D, 1'b0);
    check_eq("basic_partial_acc", 32'(acc), 32'd45);
    check_eq("basic_early_valid", 32'(acc_valid), 32'd0);
    send(16'h0029, 1'b0);
    check_eq("basic_valid",    32'(acc_valid), 32'd1);
    check_eq("basic_acc",      32'(acc), 32'd86);
    check_eq("basic_ovf",      32'(ovf), 32'd0);
    check_eq("done_in_ready",  32'(in_ready), 32'd0);
    // Start presented on the handoff edge must not open a batch.
    start = 1'b1;
    len   = 8'd1;
    tick();
    start = 1'b0;
    check_eq("handoff_start_ignored", 32'(busy), 32'd0);
    check_eq("idle_acc_held",         32'(acc), 32'd86);
    tick();

    // Carry inclusion.
    push_exp(18'h1FFFF, 1'b0);
    start_batch(8'd1);
    send(16'hFFFF, 1'b1);
    check_eq("carry_valid", 32'(acc_valid), 32'd1);
    check_eq("carry_acc",   32'(acc), 32'h1FFFF);
    tick();

    // Overflow: 3 x 0x1FFFF = 0x5FFFD, wraps to 0x1FFFD in 18 bits.
    push_exp(18'h1FFFD, 1'b1);
    start_batch(8'd3);
    send(16'hFFFF, 1'b1);
    check_eq("ovf_not_yet", 32'(ovf), 32'd0);
    send(16'hFFFF, 1'b1);
    send(16'hFFFF, 1'b1);
    check_eq("ovf_acc",  32'(acc), 32'h1FFFD);
    check_eq("ovf_flag", 32'(ovf), 32'd1);
    tick();
    check_eq("ovf_sticky_idle", 32'(ovf), 32'd1);

    // Zero-length batch; its start also clears ovf.
    push_exp(18'd0, 1'b0);
    start_batch(8'd0);
    check_eq("zero_valid",    32'(acc_valid), 32'd1);
    check_eq("zero_acc",      32'(acc), 32'd0);
    check_eq("zero_ovf_clr",  32'(ovf), 32'd0);
    check_eq("zero_in_ready", 32'(in_ready), 32'd0);
    tick();

    // Stall and backpressure; a start held during ACCUM must be ignored.
    acc_ready = 1'b0;
    push_exp(18'd86, 1'b0);
    start_batch(8'd2);
    start = 1'b1;
    len   = 8'd5;
    repeat (3) tick();
    check_eq("stall_acc0",     32'(acc), 32'd0);
    check_eq("stall_in_ready", 32'(in_ready), 32'd1);
    send(16'h002D, 1'b0);
    repeat (3) tick();
    check_eq("stall_acc1", 32'(acc), 32'd45);
    send(16'h0029, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(acc_valid), 32'd1);
      check_eq("bp_acc",   32'(acc), 32'd86);
      tick();
    end
    start     = 1'b0;
    acc_ready = 1'b1;
    check_eq("bp_still_busy", 32'(busy), 32'd1);
    tick();
    check_eq("bp_idle", 32'(busy), 32'd0);
    tick();

    // Reset mid-batch: abandoned, no total issued.
    start_batch(8'd4);
    send(16'd7, 1'b0);
    send(16'd9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_acc",       32'(acc), 32'd0);
    check_eq("mid_rst_in_ready",  32'(in_ready), 32'd0);
    check_eq("mid_rst_busy",      32'(busy), 32'd0);
    check_eq("mid_rst_acc_valid", 32'(acc_valid), 32'd0);
    check_eq("mid_rst_ovf",       32'(ovf), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    // First start after reset release is honoured on the first edge.
    push_exp(18'd7, 1'b0);
    start_batch(8'd1);
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(16'd7, 1'b0);
    check_eq("post_rst_acc", 32'(acc), 32'd7);
    tick();
    repeat (3) tick();

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
